// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   - FSM state encoding (IDLE, ISSUE, RESP), 2 bits wide.
//   - Port identifiers: PORT_IF is instruction fetch, PORT_DM is data load/store.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration between the ports).
package mem_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t RESP  = 2'd2;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/arb2_sel.sv
// Combinational two-way request selector.
// Ports:
//   req0, req1  in   requests, already qualified by the caller
//   prio        in   port favoured when both requests are present (round-robin only)
//   gnt         out  one-hot grant, bit index = port ID; zero when nothing requests
// Macro MEM_ARB_RR_EN: defined -> prio decides ties; undefined -> port 0 always wins.
module arb2_sel
   import mem_arb_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  logic       prio,
   output logic [1:0] gnt
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      // NOTE: default every output first so no path through the block infers a latch.
      gnt = 2'b00;
      if (req0 && req1) begin
         gnt[PORT_DM] = (prio == PORT_DM);
         gnt[PORT_IF] = (prio == PORT_IF);
      end else begin
         gnt[PORT_IF] = req0;
         gnt[PORT_DM] = req1;
      end
   end
`else
   // The tie-break input has no meaning with fixed priority.
   logic unused_prio;
   assign unused_prio = prio;

   always_comb begin
      gnt          = 2'b00;
      gnt[PORT_IF] = req0;
      gnt[PORT_DM] = req1 && !req0;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and sequencer for a shared single-port word memory.
// Port 0 is instruction fetch, port 1 is the data load/store unit. One access at
// a time: grant (IDLE/RESP) -> memory access (ISSUE) -> response pulse (RESP).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req/we/addr/wdata 0,1   request, 1=write, byte address, write data
//   gnt0, gnt1              combinational one-cycle accept pulse
//   rvalid0/1, rdata0/1     registered one-cycle response; rdata is 0 for write acks
//   mem_address, mem_data_in, mem_read, mem_write   drive the memory pins
//   mem_data_out            memory read data (tri-stated while mem_read=0)
// Macro MEM_ARB_RR_EN: defined -> round-robin between ports; undefined -> port 0 priority.
module mem_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_data_out
);
   import mem_arb_pkg::*;

   state_t            state, next_state;
   logic              prio;
   logic              can_grant;
   logic              qreq0, qreq1;
   logic [1:0]        sel_gnt;
   logic              any_gnt;
   logic              issue;

   logic              reg_port;
   logic              reg_we;
   logic [ADDR_W-1:0] reg_addr;
   logic [DATA_W-1:0] reg_wdata;

   // Grants are only legal in IDLE and RESP, and are suppressed while reset is
   // held so that gnt reads 0 during reset even though the FSM sits in IDLE.
   assign can_grant = rst_n && ((state == IDLE) || (state == RESP));
   assign qreq0     = req0 && can_grant;
   assign qreq1     = req1 && can_grant;

   arb2_sel u_sel (
      .req0 (qreq0),
      .req1 (qreq1),
      .prio (prio),
      .gnt  (sel_gnt)
   );

   assign gnt0    = sel_gnt[PORT_IF];
   assign gnt1    = sel_gnt[PORT_DM];
   assign any_gnt = |sel_gnt;

`ifdef MEM_ARB_RR_EN
   // Pointer always names the port that lost the latest grant, so a lone
   // requester also moves it to the other port.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n)       prio <= PORT_IF;
      else if (any_gnt) prio <= gnt0 ? PORT_DM : PORT_IF;
   end
`else
   assign prio = PORT_IF;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_gnt) next_state = ISSUE;
         ISSUE:   next_state = RESP;
         RESP:    next_state = any_gnt ? ISSUE : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Winner's request is captured at the grant edge; requesters may change
   // their inputs freely afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_port  <= PORT_IF;
         reg_we    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else if (any_gnt) begin
         reg_port  <= gnt1 ? PORT_DM : PORT_IF;
         reg_we    <= gnt1 ? we1    : we0;
         reg_addr  <= gnt1 ? addr1  : addr0;
         reg_wdata <= gnt1 ? wdata1 : wdata0;
      end
   end

   // Memory pins are decoded from state, so an asynchronous reset in ISSUE
   // drops mem_read/mem_write at once.
   assign issue       = (state == ISSUE);
   assign mem_read    = issue && !reg_we;
   assign mem_write   = issue &&  reg_we;
   assign mem_address = issue ? reg_addr  : '0;
   assign mem_data_in = issue ? reg_wdata : '0;

   // Response registers load only at the closing edge of ISSUE and clear on
   // every other edge, giving a single-cycle pulse. mem_data_out is taken only
   // when mem_read is high, so a floating bus is never captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= issue && (reg_port == PORT_IF);
         rvalid1 <= issue && (reg_port == PORT_DM);
         rdata0  <= (mem_read && (reg_port == PORT_IF)) ? mem_data_out : '0;
         rdata1  <= (mem_read && (reg_port == PORT_DM)) ? mem_data_out : '0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
// Inputs change and outputs are checked just after the falling clock edge.
// Honours MEM_ARB_RR_EN for the contention scenario.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_address, mem_data_in, mem_data_out;
   logic        mem_read, mem_write;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [16];

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req0),
      .we0          (we0),
      .addr0        (addr0),
      .wdata0       (wdata0),
      .req1         (req1),
      .we1          (we1),
      .addr1        (addr1),
      .wdata1       (wdata1),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .rvalid0      (rvalid0),
      .rdata0       (rdata0),
      .rvalid1      (rvalid1),
      .rdata1       (rdata1),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_data_out (mem_data_out)
   );

   // Word memory: asynchronous read, tri-stated when not read, write at the edge.
   assign mem_data_out = mem_read ? mem[mem_address[5:2]] : 32'hzzzz_zzzz;

   always @(posedge clk) begin
      if (mem_write) mem[mem_address[5:2]] <= mem_data_in;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   logic [6:0] exp_g0, exp_g1;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
`ifdef MEM_ARB_RR_EN
      exp_g0 = 7'b001_0001;
      exp_g1 = 7'b100_0100;
`else
      exp_g0 = 7'b101_0101;
      exp_g1 = 7'b000_0000;
`endif

      // 1. Reset held with req0 asserted, then first grant.
      rst_n = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;  wdata0 = 32'h0;
      req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0;  wdata1 = 32'h0;
      step(); step();
      #1;
      check("rst_gnt0",    {31'b0, gnt0},    32'd0);
      check("rst_gnt1",    {31'b0, gnt1},    32'd0);
      check("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
      check("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
      check("rst_rd",      {31'b0, mem_read},  32'd0);
      check("rst_wr",      {31'b0, mem_write}, 32'd0);
      check("rst_addr",    mem_address, 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("first_gnt0", {31'b0, gnt0}, 32'd1);
      step();                                   // ISSUE
      req0 = 1'b0;
      #1;
      check("t1_mem_read", {31'b0, mem_read}, 32'd1);
      check("t1_addr",     mem_address, 32'h0);
      step();                                   // RESP
      #1;
      check("t1_rvalid0", {31'b0, rvalid0}, 32'd1);
      check("t1_rdata0",  rdata0, 32'h1000_0000);
      step();                                   // IDLE
      #1;
      check("t1_rvalid0_off", {31'b0, rvalid0}, 32'd0);
      check("t1_rdata0_off",  rdata0, 32'd0);

      // 2. Port 1 write 0xDEADBEEF to 0x10, then read it back.
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h10; wdata1 = 32'hDEAD_BEEF;
      #1;
      check("t2_gnt1", {31'b0, gnt1}, 32'd1);
      check("t2_gnt0", {31'b0, gnt0}, 32'd0);
      step();                                   // ISSUE (write)
      req1 = 1'b0;
      #1;
      check("t2_wr",   {31'b0, mem_write}, 32'd1);
      check("t2_rd",   {31'b0, mem_read},  32'd0);
      check("t2_addr", mem_address, 32'h10);
      check("t2_din",  mem_data_in, 32'hDEAD_BEEF);
      step();                                   // RESP (ack)
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; wdata1 = 32'h0;
      #1;
      check("t2_wr_one_cycle", {31'b0, mem_write}, 32'd0);
      check("t2_ack_rvalid1",  {31'b0, rvalid1},   32'd1);
      check("t2_ack_rdata1",   rdata1, 32'd0);
      check("t2_ack_rvalid0",  {31'b0, rvalid0},   32'd0);
      check("t2_resp_gnt1",    {31'b0, gnt1},      32'd1);
      step();                                   // ISSUE (read)
      req1 = 1'b0;
      #1;
      check("t2_rd_issue",  {31'b0, mem_read}, 32'd1);
      check("t2_rvalid1_gap", {31'b0, rvalid1}, 32'd0);
      step();                                   // RESP
      #1;
      check("t2_rd_rvalid1", {31'b0, rvalid1}, 32'd1);
      check("t2_rd_rdata1",  rdata1, 32'hDEAD_BEEF);
      step();                                   // IDLE

      // 3/4. Both ports request continuously.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
      for (int k = 0; k < 7; k++) begin
         #1;
         check($sformatf("cont_gnt0_c%0d", k), {31'b0, gnt0}, {31'b0, exp_g0[k]});
         check($sformatf("cont_gnt1_c%0d", k), {31'b0, gnt1}, {31'b0, exp_g1[k]});
         check($sformatf("cont_excl_c%0d", k), {31'b0, gnt0 & gnt1}, 32'd0);
         if (k == 2) begin
            check("cont_rvalid0_c2", {31'b0, rvalid0}, 32'd1);
            check("cont_rdata0_c2",  rdata0, 32'h1000_0001);
         end
         step();
      end
      // c7 is ISSUE; c8 is RESP with req0 dropped -> port 1 wins.
      step();
      req0 = 1'b0;
      #1;
      check("c8_gnt1", {31'b0, gnt1}, 32'd1);
      check("c8_gnt0", {31'b0, gnt0}, 32'd0);
      step();                                   // ISSUE
      req1 = 1'b0;
      step();                                   // RESP
      #1;
      check("c10_rvalid1", {31'b0, rvalid1}, 32'd1);
      check("c10_rdata1",  rdata1, 32'h1000_0002);
      step();                                   // IDLE

      // 5. Reset asserted in the middle of a read's ISSUE cycle.
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'hC;
      #1;
      check("t5_gnt0", {31'b0, gnt0}, 32'd1);
      step();                                   // ISSUE
      req0 = 1'b0;
      #1;
      check("t5_rd_before", {31'b0, mem_read}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_rd_async", {31'b0, mem_read}, 32'd0);
      check("t5_addr_async", mem_address, 32'd0);
      step();
      #1;
      check("t5_no_rvalid0", {31'b0, rvalid0}, 32'd0);
      rst_n = 1'b1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
      #1;
      check("t5_idle_gnt1", {31'b0, gnt1}, 32'd1);
      step();                                   // ISSUE

      // 6. req0 pulsed during ISSUE only: must not be granted or accessed.
      req1 = 1'b0;
      req0 = 1'b1; addr0 = 32'h0;
      #1;
      check("t6_issue_gnt0", {31'b0, gnt0}, 32'd0);
      step();                                   // RESP
      req0 = 1'b0;
      #1;
      check("t6_resp_gnt0",  {31'b0, gnt0},    32'd0);
      check("t6_rvalid1",    {31'b0, rvalid1}, 32'd1);
      check("t6_rdata1",     rdata1, 32'h1000_0005);
      step();                                   // IDLE
      #1;
      check("t6_idle_rd", {31'b0, mem_read},  32'd0);
      check("t6_idle_wr", {31'b0, mem_write}, 32'd0);
      step();
      #1;
      check("t6_late_rd",      {31'b0, mem_read}, 32'd0);
      check("t6_late_rvalid0", {31'b0, rvalid0},  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
